// File: rtl/pong_scoreboard.sv
// rtl/pong_scoreboard.sv - Pong score keeping, match sequencing and seven-segment digit drive
module pong_scoreboard #(
  parameter int CLKS_PER_PAUSE = 25000000,
  parameter int FLASH_CLKS     = 12500000,
  parameter int WIN_SCORE      = 9
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic       i_Left_Point,
  input  logic       i_Right_Point,
  output logic       o_Game_Active,
  output logic       o_Serve_Dir,
  output logic [1:0] o_Winner,
  output logic [6:0] o_Segment1,
  output logic [6:0] o_Segment2
);

  localparam int PW = $clog2(CLKS_PER_PAUSE + 1);
  localparam int FW = $clog2(FLASH_CLKS + 1);
  localparam logic [PW-1:0] PAUSE_LOAD = PW'(CLKS_PER_PAUSE - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CLKS - 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
  localparam logic [6:0]    SEG_ZERO   = 7'b1000000;
  localparam logic [6:0]    SEG_BLANK  = 7'b1111111;

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, GAME_OVER} state_t;

  state_t        state;
  logic          start_prev, left_prev, right_prev;
  logic          start_edge, left_edge, right_edge;
  logic [3:0]    left_score, right_score;
  logic [3:0]    left_next, right_next;
  logic [PW-1:0] pause_cnt;
  logic [FW-1:0] flash_cnt;
  logic          flash_blank;

  assign start_edge = i_Start & ~start_prev;
  assign left_edge  = i_Left_Point & ~left_prev;
  assign right_edge = i_Right_Point & ~right_prev;
  assign left_next  = left_score + 4'd1;
  assign right_next = right_score + 4'd1;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  // Prev registers come out of reset high so a level held through reset is not an edge.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      start_prev <= 1'b1;
      left_prev  <= 1'b1;
      right_prev <= 1'b1;
    end else begin
      start_prev <= i_Start;
      left_prev  <= i_Left_Point;
      right_prev <= i_Right_Point;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state         <= IDLE;
      left_score    <= 4'd0;
      right_score   <= 4'd0;
      o_Game_Active <= 1'b0;
      o_Serve_Dir   <= 1'b1;
      o_Winner      <= 2'b00;
      pause_cnt     <= '0;
      flash_cnt     <= '0;
      flash_blank   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge) begin
            state         <= PLAY;
            o_Game_Active <= 1'b1;
          end
        end
        PLAY: begin
          // Simultaneous point edges are treated as a non-event.
          if (left_edge ^ right_edge) begin
            o_Game_Active <= 1'b0;
            flash_cnt     <= '0;
            flash_blank   <= 1'b0;
            if (left_edge) begin
              left_score  <= left_next;
              o_Serve_Dir <= 1'b1;
              if (left_next == WIN) begin
                state    <= GAME_OVER;
                o_Winner <= 2'b01;
              end else begin
                state     <= PAUSE;
                pause_cnt <= PAUSE_LOAD;
              end
            end else begin
              right_score <= right_next;
              o_Serve_Dir <= 1'b0;
              if (right_next == WIN) begin
                state    <= GAME_OVER;
                o_Winner <= 2'b10;
              end else begin
                state     <= PAUSE;
                pause_cnt <= PAUSE_LOAD;
              end
            end
          end
        end
        PAUSE: begin
          if (pause_cnt == '0) begin
            state         <= PLAY;
            o_Game_Active <= 1'b1;
          end else begin
            pause_cnt <= pause_cnt - PW'(1);
          end
        end
        GAME_OVER: begin
          if (start_edge) begin
            state         <= PLAY;
            o_Game_Active <= 1'b1;
            left_score    <= 4'd0;
            right_score   <= 4'd0;
            o_Winner      <= 2'b00;
            o_Serve_Dir   <= 1'b1;
            flash_cnt     <= '0;
            flash_blank   <= 1'b0;
          end else if (flash_cnt == FLASH_LAST) begin
            flash_cnt   <= '0;
            flash_blank <= ~flash_blank;
          end else begin
            flash_cnt <= flash_cnt + FW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digits lag the score/phase registers by one clock.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Segment1 <= SEG_ZERO;
      o_Segment2 <= SEG_ZERO;
    end else begin
      o_Segment1 <= (flash_blank && o_Winner == 2'b01) ? SEG_BLANK : seg_decode(left_score);
      o_Segment2 <= (flash_blank && o_Winner == 2'b10) ? SEG_BLANK : seg_decode(right_score);
    end
  end

endmodule

// File: tb/tb_pong_scoreboard.sv
// tb/tb_pong_scoreboard.sv - scoreboard-queue bench for pong_scoreboard
module tb_pong_scoreboard;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] SB = 7'b1111111;

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] RST  = 4'b1000;
  localparam logic [3:0] ST   = 4'b0100;
  localparam logic [3:0] LP   = 4'b0010;
  localparam logic [3:0] RP   = 4'b0001;

  logic       i_Clk = 1'b0;
  logic       i_Rst, i_Start, i_Left_Point, i_Right_Point;
  logic       o_Game_Active, o_Serve_Dir;
  logic [1:0] o_Winner;
  logic [6:0] o_Segment1, o_Segment2;

  typedef struct {
    string       nm;
    logic [17:0] v;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] stim_q[$];
  int         checks = 0;
  int         errors = 0;

  pong_scoreboard #(
    .CLKS_PER_PAUSE(4),
    .FLASH_CLKS(3),
    .WIN_SCORE(3)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .i_Start(i_Start),
    .i_Left_Point(i_Left_Point),
    .i_Right_Point(i_Right_Point),
    .o_Game_Active(o_Game_Active),
    .o_Serve_Dir(o_Serve_Dir),
    .o_Winner(o_Winner),
    .o_Segment1(o_Segment1),
    .o_Segment2(o_Segment2)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic logic [17:0] exp_vec(input logic [6:0] s1, input logic [6:0] s2,
                                          input logic act, input logic dir, input logic [1:0] win);
    return {s1, s2, act, dir, win};
  endfunction

  function automatic logic [17:0] observed();
    return {o_Segment1, o_Segment2, o_Game_Active, o_Serve_Dir, o_Winner};
  endfunction

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic plan(input logic [3:0] stim, input string nm, input logic [17:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    stim_q.push_back(stim);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int c = 0; c < 2; c++) plan(RST | ST | LP, "reset_state", exp_vec(S0, S0, 1'b0, 1'b1, 2'b00));
    for (int c = 0; c < 3; c++) plan(ST | LP, "held_through_reset", exp_vec(S0, S0, 1'b0, 1'b1, 2'b00));
    plan(NONE, "idle_hold", exp_vec(S0, S0, 1'b0, 1'b1, 2'b00));
    while (stim_q.size() != 0) begin
      {i_Rst, i_Start, i_Left_Point, i_Right_Point} = stim_q.pop_front();
      tick();
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e.v) begin
        errors++;
        $display("FAIL %s got %b want %b", e.nm, observed(), e.v);
      end
    end
  endtask

  task automatic test_serve_pause();
    exp_t e;
    plan(ST, "start_play", exp_vec(S0, S0, 1'b1, 1'b1, 2'b00));
    plan(NONE, "play_steady", exp_vec(S0, S0, 1'b1, 1'b1, 2'b00));
    plan(LP, "left_score_edge", exp_vec(S0, S0, 1'b0, 1'b1, 2'b00));
    for (int c = 0; c < 3; c++) plan(NONE, "pause_left_one", exp_vec(S1, S0, 1'b0, 1'b1, 2'b00));
    plan(NONE, "pause_over", exp_vec(S1, S0, 1'b1, 1'b1, 2'b00));
    while (stim_q.size() != 0) begin
      {i_Rst, i_Start, i_Left_Point, i_Right_Point} = stim_q.pop_front();
      tick();
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e.v) begin
        errors++;
        $display("FAIL %s got %b want %b", e.nm, observed(), e.v);
      end
    end
  endtask

  task automatic test_both_and_pause();
    exp_t e;
    plan(LP | RP, "both_ignored", exp_vec(S1, S0, 1'b1, 1'b1, 2'b00));
    plan(NONE, "both_after", exp_vec(S1, S0, 1'b1, 1'b1, 2'b00));
    plan(RP, "right_score_edge", exp_vec(S1, S0, 1'b0, 1'b0, 2'b00));
    plan(NONE, "right_seg_one", exp_vec(S1, S1, 1'b0, 1'b0, 2'b00));
    plan(LP, "pause_point_ignored", exp_vec(S1, S1, 1'b0, 1'b0, 2'b00));
    plan(NONE, "pause_tail", exp_vec(S1, S1, 1'b0, 1'b0, 2'b00));
    plan(NONE, "pause_done", exp_vec(S1, S1, 1'b1, 1'b0, 2'b00));
    plan(ST, "start_ignored_play", exp_vec(S1, S1, 1'b1, 1'b0, 2'b00));
    plan(NONE, "play_after_start", exp_vec(S1, S1, 1'b1, 1'b0, 2'b00));
    while (stim_q.size() != 0) begin
      {i_Rst, i_Start, i_Left_Point, i_Right_Point} = stim_q.pop_front();
      tick();
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e.v) begin
        errors++;
        $display("FAIL %s got %b want %b", e.nm, observed(), e.v);
      end
    end
  endtask

  task automatic test_game_over();
    exp_t       e;
    logic [6:0] seg2;
    plan(RP, "right_two_edge", exp_vec(S1, S1, 1'b0, 1'b0, 2'b00));
    for (int c = 0; c < 3; c++) plan(NONE, "pause_right_two", exp_vec(S1, S2, 1'b0, 1'b0, 2'b00));
    plan(NONE, "play_before_win", exp_vec(S1, S2, 1'b1, 1'b0, 2'b00));
    plan(RP, "win_edge", exp_vec(S1, S2, 1'b0, 1'b0, 2'b10));
    for (int g = 1; g <= 10; g++) begin
      seg2 = (((g - 1) / 3) % 2 == 1) ? SB : S3;
      plan((g == 2) ? LP : NONE, $sformatf("flash_c%0d", g), exp_vec(S1, seg2, 1'b0, 1'b0, 2'b10));
    end
    while (stim_q.size() != 0) begin
      {i_Rst, i_Start, i_Left_Point, i_Right_Point} = stim_q.pop_front();
      tick();
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e.v) begin
        errors++;
        $display("FAIL %s got %b want %b", e.nm, observed(), e.v);
      end
    end
  endtask

  task automatic test_restart();
    exp_t e;
    plan(ST, "restart_edge", exp_vec(S1, SB, 1'b1, 1'b1, 2'b00));
    plan(NONE, "restart_segs", exp_vec(S0, S0, 1'b1, 1'b1, 2'b00));
    while (stim_q.size() != 0) begin
      {i_Rst, i_Start, i_Left_Point, i_Right_Point} = stim_q.pop_front();
      tick();
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e.v) begin
        errors++;
        $display("FAIL %s got %b want %b", e.nm, observed(), e.v);
      end
    end
  endtask

  task automatic test_reset_in_pause();
    exp_t e;
    plan(LP, "pre_reset_point", exp_vec(S0, S0, 1'b0, 1'b1, 2'b00));
    plan(NONE, "in_pause", exp_vec(S1, S0, 1'b0, 1'b1, 2'b00));
    plan(RST, "reset_in_pause", exp_vec(S0, S0, 1'b0, 1'b1, 2'b00));
    for (int c = 0; c < 5; c++) plan(NONE, "idle_after_reset", exp_vec(S0, S0, 1'b0, 1'b1, 2'b00));
    plan(ST, "start_after_reset", exp_vec(S0, S0, 1'b1, 1'b1, 2'b00));
    plan(NONE, "play_after_reset", exp_vec(S0, S0, 1'b1, 1'b1, 2'b00));
    plan(LP, "post_reset_point", exp_vec(S0, S0, 1'b0, 1'b1, 2'b00));
    for (int c = 0; c < 3; c++) plan(NONE, "post_reset_pause", exp_vec(S1, S0, 1'b0, 1'b1, 2'b00));
    plan(NONE, "post_reset_play", exp_vec(S1, S0, 1'b1, 1'b1, 2'b00));
    while (stim_q.size() != 0) begin
      {i_Rst, i_Start, i_Left_Point, i_Right_Point} = stim_q.pop_front();
      tick();
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e.v) begin
        errors++;
        $display("FAIL %s got %b want %b", e.nm, observed(), e.v);
      end
    end
  endtask

  initial begin
    i_Rst         = 1'b1;
    i_Start       = 1'b1;
    i_Left_Point  = 1'b1;
    i_Right_Point = 1'b0;
    test_reset();
    test_serve_pause();
    test_both_and_pause();
    test_game_over();
    test_restart();
    test_reset_in_pause();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
